// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial_to_parallel receiver.
package s2p_pkg;

    typedef enum logic {
        S2P_IDLE  = 1'b0,
        S2P_SHIFT = 1'b1
    } s2p_state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/s2p_out_reg.sv
// Valid/ready output word register with sticky overrun flag.
module s2p_out_reg
    import s2p_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             word_done,
    input  logic [WIDTH-1:0] word_data,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             out_valid_o,
    output logic             overrun_o
);

    logic xfer;
    logic load;

    assign xfer = out_valid_o & out_ready_i;
    // A new word may load only when the slot is empty or draining now.
    assign load = word_done & (~out_valid_o | out_ready_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            parallel_o  <= '0;
            out_valid_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (load) begin
                parallel_o  <= word_data;
                out_valid_o <= 1'b1;
            end else if (xfer) begin
                out_valid_o <= 1'b0;
            end
            if (clr_i) begin
                overrun_o <= 1'b0;
            end else if (word_done && !load) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel receiver: bit assembly FSM feeding a valid/ready word register.
module serial_to_parallel
    import s2p_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1,
    localparam int CNT_W    = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_i,
    input  logic             valid_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic             busy_o,
    output logic             overrun_o
);

    s2p_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt, shifted;
    logic             word_done;
    logic             last_bit;

    assign shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], serial_i}
                                      : {serial_i, shreg[WIDTH-1:1]};
    assign last_bit = (bit_cnt_o == CNT_W'(WIDTH - 1));
    assign busy_o = (bit_cnt_o != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S2P_IDLE;
            bit_cnt_o <= '0;
            shreg     <= '0;
        end else begin
            state     <= state_nxt;
            bit_cnt_o <= cnt_nxt;
            shreg     <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt_o;
        shreg_nxt = shreg;
        word_done = 1'b0;
        if (clr_i) begin
            state_nxt = S2P_IDLE;
            cnt_nxt   = '0;
            shreg_nxt = '0;
        end else if (valid_i) begin
            unique case (state)
                S2P_IDLE: begin
                    state_nxt = S2P_SHIFT;
                    cnt_nxt   = CNT_W'(1);
                    shreg_nxt = shifted;
                end
                S2P_SHIFT: begin
                    if (last_bit) begin
                        state_nxt = S2P_IDLE;
                        cnt_nxt   = '0;
                        shreg_nxt = '0;
                        word_done = 1'b1;
                    end else begin
                        cnt_nxt   = bit_cnt_o + CNT_W'(1);
                        shreg_nxt = shifted;
                    end
                end
                default: begin
                    state_nxt = S2P_IDLE;
                end
            endcase
        end
    end

    s2p_out_reg #(
        .WIDTH(WIDTH)
    ) u_out (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_i),
        .word_done  (word_done),
        .word_data  (shifted),
        .out_ready_i(out_ready_i),
        .parallel_o (parallel_o),
        .out_valid_o(out_valid_o),
        .overrun_o  (overrun_o)
    );

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench for serial_to_parallel, MSB-first and LSB-first instances.
module tb_serial_to_parallel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial = 1'b0;
    logic       valid = 1'b0;
    logic       clr = 1'b0;
    logic       ready = 1'b0;

    logic [3:0] m_par, l_par;
    logic       m_valid, l_valid;
    logic [2:0] m_cnt, l_cnt;
    logic       m_busy, l_busy;
    logic       m_ovr, l_ovr;

    logic [3:0] exp_q[$];
    logic [3:0] exp_l[$];
    logic [3:0] exp;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    serial_to_parallel #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .serial_i(serial), .valid_i(valid),
        .clr_i(clr), .parallel_o(m_par), .out_valid_o(m_valid),
        .out_ready_i(ready), .bit_cnt_o(m_cnt), .busy_o(m_busy),
        .overrun_o(m_ovr)
    );

    serial_to_parallel #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .serial_i(serial), .valid_i(valid),
        .clr_i(clr), .parallel_o(l_par), .out_valid_o(l_valid),
        .out_ready_i(ready), .bit_cnt_o(l_cnt), .busy_o(l_busy),
        .overrun_o(l_ovr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        valid = 1'b1;
        serial = b;
        step();
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        checks++;
        if (m_par !== 4'h0) begin errors++; $display("FAIL reset_par got=%h exp=0", m_par); end
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        checks++;
        if (m_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", m_cnt); end
        checks++;
        if (m_busy !== 1'b0 || m_ovr !== 1'b0) begin
            errors++; $display("FAIL reset_busy_ovr got=%b%b exp=00", m_busy, m_ovr);
        end
        checks++;
        if (l_par !== 4'h0 || l_valid !== 1'b0) begin
            errors++; $display("FAIL reset_lsb got=%h/%b exp=0/0", l_par, l_valid);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        ready = 1'b1;
        exp_q.push_back(4'hB);
        send_bit(1); send_bit(0); send_bit(1);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", m_valid); end
        send_bit(1);
        exp = exp_q.pop_front();
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", m_valid); end
        checks++;
        if (m_par !== exp) begin errors++; $display("FAIL basic_par got=%h exp=%h", m_par, exp); end
        checks++;
        if (m_ovr !== 1'b0 || m_cnt !== 3'd0) begin
            errors++; $display("FAIL basic_ovr_cnt got=%b/%0d exp=0/0", m_ovr, m_cnt);
        end
        step();
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got=%b exp=0", m_valid); end
        checks++;
        if (m_par !== 4'hB) begin errors++; $display("FAIL basic_retain got=%h exp=b", m_par); end
    endtask

    task automatic test_gapped();
        ready = 1'b1;
        exp_q.push_back(4'h6);
        exp_l.push_back(4'h6);
        send_bit(0);
        idle(1);
        checks++;
        if (m_cnt !== 3'd1 || m_busy !== 1'b1) begin
            errors++; $display("FAIL gap1_hold got=%0d/%b exp=1/1", m_cnt, m_busy);
        end
        send_bit(1);
        idle(3);
        checks++;
        if (m_cnt !== 3'd2 || m_busy !== 1'b1 || l_cnt !== 3'd2) begin
            errors++; $display("FAIL gap3_hold got=%0d/%b/%0d exp=2/1/2", m_cnt, m_busy, l_cnt);
        end
        send_bit(1);
        send_bit(0);
        exp = exp_q.pop_front();
        checks++;
        if (m_valid !== 1'b1 || m_par !== exp) begin
            errors++; $display("FAIL gap_msb_word got=%h/%b exp=%h/1", m_par, m_valid, exp);
        end
        exp = exp_l.pop_front();
        checks++;
        if (l_valid !== 1'b1 || l_par !== exp) begin
            errors++; $display("FAIL gap_lsb_word got=%h/%b exp=%h/1", l_par, l_valid, exp);
        end
        exp_q.push_back(4'h7);
        exp_l.push_back(4'hE);
        send_bit(0); send_bit(1); send_bit(1); send_bit(1);
        exp = exp_q.pop_front();
        checks++;
        if (m_valid !== 1'b1 || m_par !== exp) begin
            errors++; $display("FAIL order_msb_word got=%h/%b exp=%h/1", m_par, m_valid, exp);
        end
        exp = exp_l.pop_front();
        checks++;
        if (l_valid !== 1'b1 || l_par !== exp) begin
            errors++; $display("FAIL order_lsb_word got=%h/%b exp=%h/1", l_par, l_valid, exp);
        end
        step();
    endtask

    task automatic test_back_pressure();
        logic [3:0] held;
        ready = 1'b0;
        exp_q.push_back(4'hA);
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        held = exp_q.pop_front();
        checks++;
        if (m_valid !== 1'b1 || m_par !== held) begin
            errors++; $display("FAIL bp_first got=%h/%b exp=%h/1", m_par, m_valid, held);
        end
        send_bit(0); send_bit(1); send_bit(0);
        checks++;
        if (m_ovr !== 1'b0) begin errors++; $display("FAIL bp_early_ovr got=%b exp=0", m_ovr); end
        send_bit(1);
        checks++;
        if (m_par !== held || m_valid !== 1'b1) begin
            errors++; $display("FAIL bp_held got=%h/%b exp=%h/1", m_par, m_valid, held);
        end
        checks++;
        if (m_ovr !== 1'b1) begin errors++; $display("FAIL bp_overrun got=%b exp=1", m_ovr); end
        ready = 1'b1;
        step();
        ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || m_ovr !== 1'b1) begin
            errors++; $display("FAIL bp_drain got=%b/%b exp=0/1", m_valid, m_ovr);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (m_ovr !== 1'b0 || l_ovr !== 1'b0) begin
            errors++; $display("FAIL bp_clr got=%b/%b exp=0/0", m_ovr, l_ovr);
        end
    endtask

    task automatic test_same_edge();
        ready = 1'b0;
        exp_q.push_back(4'h3);
        send_bit(0); send_bit(0); send_bit(1); send_bit(1);
        exp = exp_q.pop_front();
        checks++;
        if (m_valid !== 1'b1 || m_par !== exp) begin
            errors++; $display("FAIL se_hold got=%h/%b exp=%h/1", m_par, m_valid, exp);
        end
        exp_q.push_back(4'hC);
        send_bit(1); send_bit(1); send_bit(0);
        ready = 1'b1;
        send_bit(0);
        ready = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (m_par !== exp) begin errors++; $display("FAIL se_word got=%h exp=%h", m_par, exp); end
        checks++;
        if (m_valid !== 1'b1 || m_ovr !== 1'b0) begin
            errors++; $display("FAIL se_flags got=%b/%b exp=1/0", m_valid, m_ovr);
        end
        ready = 1'b1;
        step();
    endtask

    task automatic test_abort();
        ready = 1'b1;
        send_bit(1); send_bit(1);
        checks++;
        if (m_cnt !== 3'd2) begin errors++; $display("FAIL abort_pre got=%0d exp=2", m_cnt); end
        clr = 1'b1;
        send_bit(1);
        clr = 1'b0;
        checks++;
        if (m_cnt !== 3'd0 || m_busy !== 1'b0) begin
            errors++; $display("FAIL abort_clr got=%0d/%b exp=0/0", m_cnt, m_busy);
        end
        exp_q.push_back(4'h1);
        send_bit(0); send_bit(0); send_bit(0); send_bit(1);
        exp = exp_q.pop_front();
        checks++;
        if (m_valid !== 1'b1 || m_par !== exp) begin
            errors++; $display("FAIL abort_word got=%h/%b exp=%h/1", m_par, m_valid, exp);
        end
        step();
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        exp_q.push_back(4'h9);
        send_bit(1); send_bit(0); send_bit(0); send_bit(1);
        exp = exp_q.pop_front();
        checks++;
        if (m_valid !== 1'b1 || m_par !== exp) begin
            errors++; $display("FAIL rm_hold got=%h/%b exp=%h/1", m_par, m_valid, exp);
        end
        send_bit(1); send_bit(1); send_bit(1);
        checks++;
        if (m_cnt !== 3'd3) begin errors++; $display("FAIL rm_cnt got=%0d exp=3", m_cnt); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (m_par !== 4'h0 || m_valid !== 1'b0 || m_cnt !== 3'd0
            || m_busy !== 1'b0 || m_ovr !== 1'b0) begin
            errors++;
            $display("FAIL rm_zero got=%h/%b/%0d/%b/%b exp=0/0/0/0/0",
                     m_par, m_valid, m_cnt, m_busy, m_ovr);
        end
        ready = 1'b1;
        exp_q.push_back(4'hF);
        send_bit(1); send_bit(1); send_bit(1); send_bit(1);
        exp = exp_q.pop_front();
        checks++;
        if (m_valid !== 1'b1 || m_par !== exp) begin
            errors++; $display("FAIL rm_word got=%h/%b exp=%h/1", m_par, m_valid, exp);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_back_pressure();
        test_same_edge();
        test_abort();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
